// File: rtl/tile_flusher.sv
// Tile sequencer and SRAM flush engine: drives the shader tile by tile in raster
// order and streams each finished tile to the framebuffer. Macro: TILE_FLUSHER_PINGPONG_EN.
module tile_flusher #(
  parameter int          SCREEN_W = 640,
  parameter int          SCREEN_H = 480,
  parameter int          TILE_DIM = 8,
  parameter logic [19:0] FB_BASE  = 20'd0
) (
  input  logic                                  BOARD_CLK,
  input  logic                                  BOARD_RESET_N,
  input  logic                                  frame_start,
  output logic                                  frame_done,
  output logic                                  startRasterizing,
  input  logic                                  doneRasterizing,
  output logic                                  rasterTileID,
  output logic [9:0]                            tileOffsetX,
  output logic [9:0]                            tileOffsetY,
  input  logic [TILE_DIM-1:0][TILE_DIM-1:0][15:0] nanoTile0,
  input  logic [TILE_DIM-1:0][TILE_DIM-1:0][15:0] nanoTile1,
  output logic [19:0]                           sram_addr,
  output logic [15:0]                           sram_wdata,
  output logic                                  sram_we,
  input  logic                                  sram_ready
);

  localparam int              CW        = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
  localparam logic [CW-1:0]   IDX_MAX   = CW'(TILE_DIM - 1);
  localparam logic [CW-1:0]   IDX_ONE   = CW'(1);
  localparam logic [9:0]      OFF_STEP  = 10'(TILE_DIM);
  localparam logic [9:0]      LAST_X    = 10'(SCREEN_W - TILE_DIM);
  localparam logic [9:0]      LAST_Y    = 10'(SCREEN_H - TILE_DIM);
  localparam logic [19:0]     LINE_STEP = 20'(SCREEN_W);
  localparam logic [19:0]     BAND_STEP = 20'(SCREEN_W * TILE_DIM);

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_DONE, HANDOFF} ctrl_state_t;
  typedef enum logic [1:0] {F_IDLE, F_WRITE, F_LAST} flush_state_t;

  ctrl_state_t  ctrl_state_reg, ctrl_state_next;
  flush_state_t flush_state_reg, flush_state_next;

  logic          tile_id_reg;
  logic [9:0]    off_x_reg, off_y_reg;
  logic [19:0]   band_addr_reg;

  logic [CW-1:0] col_reg, row_reg, col_next, row_next;
  logic          buf_reg, last_reg, buf_sel;
  logic [19:0]   line_addr_reg, line_next;
  logic [19:0]   addr_reg, addr_next;
  logic [15:0]   wdata_reg, pixel_next;

  logic flush_idle, start_ok, start_pulse, handoff_fire, tile_is_last;
  logic beat_accept, beat_final, beat_advance;

  assign flush_idle   = (flush_state_reg == F_IDLE);
  assign tile_is_last = (off_x_reg == LAST_X) && (off_y_reg == LAST_Y);

`ifdef TILE_FLUSHER_PINGPONG_EN
  assign start_ok = 1'b1;
`else
  // Single buffer: the shader may only overwrite nanoTile0 once it is drained.
  assign start_ok = flush_idle;
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge BOARD_CLK or negedge BOARD_RESET_N) begin
    if (!BOARD_RESET_N) begin
      ctrl_state_reg <= IDLE;
    end else begin
      ctrl_state_reg <= ctrl_state_next;
    end
  end

  always_comb begin
    ctrl_state_next = ctrl_state_reg;
    start_pulse     = 1'b0;
    handoff_fire    = 1'b0;
    case (ctrl_state_reg)
      IDLE: begin
        if (frame_start) ctrl_state_next = START;
      end
      START: begin
        if (start_ok) begin
          start_pulse     = 1'b1;
          ctrl_state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // A done level left over from the previous tile must not count.
        if (!doneRasterizing) ctrl_state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (doneRasterizing) ctrl_state_next = HANDOFF;
      end
      HANDOFF: begin
        if (flush_idle) begin
          handoff_fire    = 1'b1;
          ctrl_state_next = tile_is_last ? IDLE : START;
        end
      end
      default: ctrl_state_next = IDLE;
    endcase
  end

  // Tile position and buffer ownership advance only at handoff.
  always_ff @(posedge BOARD_CLK or negedge BOARD_RESET_N) begin
    if (!BOARD_RESET_N) begin
      tile_id_reg   <= 1'b0;
      off_x_reg     <= 10'd0;
      off_y_reg     <= 10'd0;
      band_addr_reg <= FB_BASE;
    end else if (handoff_fire) begin
`ifdef TILE_FLUSHER_PINGPONG_EN
      tile_id_reg <= ~tile_id_reg;
`endif
      if (tile_is_last) begin
        off_x_reg     <= 10'd0;
        off_y_reg     <= 10'd0;
        band_addr_reg <= FB_BASE;
      end else if (off_x_reg == LAST_X) begin
        off_x_reg     <= 10'd0;
        off_y_reg     <= off_y_reg + OFF_STEP;
        band_addr_reg <= band_addr_reg + BAND_STEP;
      end else begin
        off_x_reg <= off_x_reg + OFF_STEP;
      end
    end
  end

  assign startRasterizing = start_pulse;
  assign rasterTileID     = tile_id_reg;
  assign tileOffsetX      = off_x_reg;
  assign tileOffsetY      = off_y_reg;

  // ---------------- flush engine ----------------
  assign beat_accept  = (flush_state_reg == F_WRITE) && sram_ready;
  assign beat_final   = beat_accept && (col_reg == IDX_MAX) && (row_reg == IDX_MAX);
  assign beat_advance = beat_accept && !beat_final;

  always_ff @(posedge BOARD_CLK or negedge BOARD_RESET_N) begin
    if (!BOARD_RESET_N) begin
      flush_state_reg <= F_IDLE;
    end else begin
      flush_state_reg <= flush_state_next;
    end
  end

  always_comb begin
    flush_state_next = flush_state_reg;
    case (flush_state_reg)
      F_IDLE: begin
        if (handoff_fire) flush_state_next = F_WRITE;
      end
      F_WRITE: begin
        if (beat_final) flush_state_next = last_reg ? F_LAST : F_IDLE;
      end
      F_LAST:  flush_state_next = F_IDLE;
      default: flush_state_next = F_IDLE;
    endcase
  end

  // Next beat is precomputed so address and data come straight from registers.
  always_comb begin
    col_next  = col_reg;
    row_next  = row_reg;
    line_next = line_addr_reg;
    addr_next = addr_reg;
    buf_sel   = buf_reg;
    if (handoff_fire) begin
      col_next  = '0;
      row_next  = '0;
      line_next = band_addr_reg + {10'd0, off_x_reg};
      addr_next = line_next;
      buf_sel   = tile_id_reg;
    end else if (beat_advance) begin
      if (col_reg == IDX_MAX) begin
        col_next  = '0;
        row_next  = row_reg + IDX_ONE;
        line_next = line_addr_reg + LINE_STEP;
        addr_next = line_next;
      end else begin
        col_next  = col_reg + IDX_ONE;
        addr_next = addr_reg + 20'd1;
      end
    end
    pixel_next = buf_sel ? nanoTile1[col_next][row_next] : nanoTile0[col_next][row_next];
  end

  always_ff @(posedge BOARD_CLK or negedge BOARD_RESET_N) begin
    if (!BOARD_RESET_N) begin
      col_reg       <= '0;
      row_reg       <= '0;
      line_addr_reg <= 20'd0;
      addr_reg      <= 20'd0;
      wdata_reg     <= 16'd0;
      buf_reg       <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      if (handoff_fire || beat_advance) begin
        col_reg       <= col_next;
        row_reg       <= row_next;
        line_addr_reg <= line_next;
        addr_reg      <= addr_next;
        wdata_reg     <= pixel_next;
      end
      if (handoff_fire) begin
        buf_reg  <= tile_id_reg;
        last_reg <= tile_is_last;
      end
    end
  end

  assign sram_we    = (flush_state_reg == F_WRITE);
  assign sram_addr  = addr_reg;
  assign sram_wdata = wdata_reg;
  assign frame_done = (flush_state_reg == F_LAST);

endmodule

// File: tb/tb_tile_flusher.sv
// Randomized scoreboard bench for tile_flusher: a shader model fills buffers and
// queues the expected SRAM beats; a monitor pops and compares accepted beats.
module tb_tile_flusher;
  localparam int W  = 40;
  localparam int H  = 24;
  localparam int TD = 8;
  localparam int TX = W / TD;
  localparam int NT = TX * (H / TD);
  localparam int NB = TD * TD;
  localparam logic [19:0] BASE = 20'hFFE00;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
    logic        last;
    logic [15:0] beat;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic frame_done, startRasterizing, rasterTileID, sram_we;
  logic done_r = 1'b1;
  logic sram_ready = 1'b0;
  logic [9:0] tileOffsetX, tileOffsetY;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [TD-1:0][TD-1:0][15:0] buf0 = '0;
  logic [TD-1:0][TD-1:0][15:0] buf1 = '0;

  beat_t exp_q[$];
  int n_cmp = 0, n_fail = 0;
  int start_cnt = 0, beat_cnt = 0, done_cnt = 0;
  int tile_k = 0, tile_g = 0;
  int ready_mode = 0, force_low = 0, stale_cfg = 0, work_min = 10, work_max = 10;

  always #5 clk = ~clk;

  tile_flusher #(.SCREEN_W(W), .SCREEN_H(H), .TILE_DIM(TD), .FB_BASE(BASE)) dut (
    .BOARD_CLK(clk), .BOARD_RESET_N(rst_n), .frame_start(frame_start),
    .frame_done(frame_done), .startRasterizing(startRasterizing),
    .doneRasterizing(done_r), .rasterTileID(rasterTileID),
    .tileOffsetX(tileOffsetX), .tileOffsetY(tileOffsetY),
    .nanoTile0(buf0), .nanoTile1(buf1), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_ready(sram_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shader model: fills the buffer named by rasterTileID and queues the tile's beats.
  task automatic fill_tile(input int k, input logic id);
    beat_t e;
    logic [15:0] px;
    int ox, oy;
    ox = (k % TX) * TD;
    oy = (k / TX) * TD;
    for (int r = 0; r < TD; r++) begin
      for (int c = 0; c < TD; c++) begin
        px = 16'($urandom);
        if (id) buf1[c][r] = px;
        else    buf0[c][r] = px;
        e.addr = 20'((int'(BASE) + (oy + r) * W + ox + c) % 1048576);
        e.data = px;
        e.last = (k == NT - 1) && (r == TD - 1) && (c == TD - 1);
        e.beat = 16'(r * TD + c);
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin : shader
    int phase, cnt, cur_k;
    logic cur_id, prev_start, was;
    phase = 0; cnt = 0; cur_k = 0; cur_id = 1'b0; prev_start = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        phase = 0; done_r = 1'b1; start_cnt = 0; tile_k = 0; tile_g = 0; prev_start = 1'b0;
        continue;
      end
      was = prev_start;
      prev_start = startRasterizing;
      if (was) begin
        check("start_one_cycle", startRasterizing, 0);
      end else if (startRasterizing) begin
        start_cnt++;
        check("start_when_shader_idle", phase, 0);
        check("tileOffsetX", tileOffsetX, (tile_k % TX) * TD);
        check("tileOffsetY", tileOffsetY, (tile_k / TX) * TD);
`ifdef TILE_FLUSHER_PINGPONG_EN
        check("rasterTileID", rasterTileID, tile_g % 2);
`else
        check("rasterTileID", rasterTileID, 0);
        check("start_vs_sram_we", sram_we, 0);
`endif
        cur_k = tile_k;
        cur_id = rasterTileID;
        tile_k = (tile_k + 1) % NT;
        tile_g++;
        cnt = stale_cfg;
        phase = 1;
      end
      if (!startRasterizing || was) begin
        if (phase == 1) begin
          if (cnt > 0) cnt--;
          else begin
            done_r = 1'b0;
            fill_tile(cur_k, cur_id);
            cnt = $urandom_range(work_min, work_max);
            phase = 2;
          end
        end else if (phase == 2) begin
          if (cnt > 0) cnt--;
          else begin
            done_r = 1'b1;
            phase = 0;
          end
        end
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      if (force_low > 0) begin
        sram_ready = 1'b0;
        force_low--;
      end else if (ready_mode == 0) begin
        sram_ready = 1'b1;
      end else begin
        sram_ready = ($urandom_range(0, 9) < 7);
      end
    end
  end

  initial begin : monitor
    beat_t e;
    logic stall, exp_done, clean;
    logic [19:0] s_addr;
    logic [15:0] s_data;
    int cyc, t0;
    stall = 1'b0; exp_done = 1'b0; clean = 1'b0; s_addr = '0; s_data = '0; cyc = 0; t0 = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stall = 1'b0; exp_done = 1'b0; beat_cnt = 0; done_cnt = 0;
        continue;
      end
      check("frame_done", frame_done, exp_done);
      if (frame_done) done_cnt++;
      exp_done = 1'b0;
      if (stall) check("hold_we_addr_data", {sram_we, sram_addr, sram_wdata}, {1'b1, s_addr, s_data});
      stall = 1'b0;
      if (sram_we && sram_ready) begin
        beat_cnt++;
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sram_addr", sram_addr, e.addr);
          check("sram_wdata", sram_wdata, e.data);
          if (e.last) exp_done = 1'b1;
          if (e.beat == 0) begin
            t0 = cyc;
            clean = 1'b1;
          end else if (e.beat == 16'(NB - 1) && clean) begin
            check("beat_gap_cycles", cyc - t0, NB - 1);
          end
        end
      end else if (sram_we) begin
        stall = 1'b1;
        s_addr = sram_addr;
        s_data = sram_wdata;
        clean = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sram_we"}, sram_we, 0);
    check({tag, "_sram_addr"}, sram_addr, 0);
    check({tag, "_sram_wdata"}, sram_wdata, 0);
    check({tag, "_start"}, startRasterizing, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_tile_id"}, rasterTileID, 0);
    check({tag, "_offx"}, tileOffsetX, 0);
    check({tag, "_offy"}, tileOffsetY, 0);
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (done_cnt < n && t < 12000) begin
      @(posedge clk);
      t++;
    end
    #1 check("frames_completed", done_cnt, n);
  endtask

  task automatic wait_beats(input int target);
    int t = 0;
    while (beat_cnt < target && t < 12000) begin
      @(posedge clk);
      t++;
    end
    #1 check("beats_reached", beat_cnt >= target, 1);
  endtask

  task automatic check_totals(input int frames);
    repeat (150) @(posedge clk);
    #1;
    check("start_count", start_cnt, frames * NT);
    check("beat_count", beat_cnt, frames * NT * NB);
    check("frame_done_count", done_cnt, frames);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin : main
    int b0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_idle("post_release");

    // Frame 1: ready held high, shader done after 10 cycles, stray frame_start mid-frame.
    pulse_start();
    repeat (40) @(posedge clk);
    pulse_start();
    wait_frames(1);
    check_totals(1);

    // Frame 2: random backpressure, stale done for 3 cycles, a forced 5-cycle stall.
    ready_mode = 1; stale_cfg = 3; work_min = 1; work_max = 20;
    b0 = beat_cnt;
    pulse_start();
    wait_beats(b0 + 100);
    force_low = 5;
    wait_frames(2);
    check_totals(2);

    // Frame 3: reset at beat 30 of tile 5, then restart from tile 0.
    stale_cfg = 1;
    b0 = beat_cnt;
    pulse_start();
    wait_beats(b0 + 5 * NB + 30);
    @(negedge clk); #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_idle("mid_reset");
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_idle("after_abort");
    pulse_start();
    wait_frames(1);
    check_totals(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
